pulse_meter: RTL
================

// Module: pulse_meter
// PURPOSE
//  Downstream consumer of the counter's 1-bit output y. Measures each full
//  high/low cycle of y in clk cycles and emits high time, low time and period
//  through a valid/ready output port. Lets the bench and the next stage check
//  the counter's waveform numerically instead of by reading VCD traces.
// PARAMETERS
//  CNT_W   8   width of high/low phase counters; period output is CNT_W+1 bits
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  reset      in   1        synchronous, active-high reset
//  y          in   1        waveform under measurement (counter output), clk-synchronous
//  m_valid    out  1        measurement held in output regs is valid
//  m_ready    in   1        consumer accepts measurement when m_valid & m_ready
//  m_high     out  CNT_W    cycles y sampled 1 in the measured period
//  m_low      out  CNT_W    cycles y sampled 0 in the measured period
//  m_period   out  CNT_W+1  m_high + m_low, full width, no truncation
//  m_sat      out  1        a phase counter saturated during this period
//  overrun    out  1        sticky: a completed measurement was dropped
// BEHAVIOUR
//  - Reset (clk edge with reset=1): state=WAIT_LOW; hi_cnt=lo_cnt=0; m_valid=0;
//    m_high=m_low=m_period=0; m_sat=0; overrun=0. Reset overrides all events,
//    including mid-period and with a pending output; partial data is discarded.
//  - FSM, evaluated on y sampled each rising clk edge:
//    WAIT_LOW: y=0 -> ARM; y=1 -> stay (never measure a partial high phase).
//    ARM:      y=1 -> HIGH, hi_cnt=1, sat_q=0; y=0 -> stay.
//    HIGH:     y=1 -> hi_cnt+1; y=0 -> LOW, lo_cnt=1.
//    LOW:      y=0 -> lo_cnt+1; y=1 -> COMPLETE: capture (hi_cnt, lo_cnt,
//              sat_q) into output path, then go to HIGH with hi_cnt=1, sat_q=0.
//              Back-to-back periods are measured with no gap cycle.
//  - Counters saturate at 2**CNT_W-1 (no wrap); saturating increment sets sat_q,
//    which is reported as m_sat on that period.
//  - Latency: m_valid rises in the cycle after the edge that samples the y=1
//    ending the LOW phase.
//  - Output handshake: m_* stable while m_valid=1 and m_ready=0.
//    On COMPLETE: if m_valid=0, or m_valid=1 with m_ready=1 in the same cycle,
//    load m_* and m_valid=1 (a simultaneous accept+load keeps m_valid=1).
//    If m_valid=1 with m_ready=0: new measurement dropped, m_* unchanged,
//    overrun set to 1 until reset.
//    No COMPLETE and m_valid & m_ready: m_valid=0 next cycle.
//  - m_period computed at CNT_W+1 bits; max 2*(2**CNT_W-1).
//  - m_ready while m_valid=0 is ignored; X on y after reset is a bench error.
// TESTING
//  1 Reset held 3 cycles, y=0 -> all outputs 0, m_valid=0, state ARM.
//  2 y = 3 high / 5 low / 1 high, m_ready=1 -> one cycle after the rising
//    sample: m_valid=1, m_high=3, m_low=5, m_period=8, m_sat=0.
//  3 y=1 from reset release for 4 cycles, then 2 low / 2 high / 2 low / 1 high
//    -> first measurement is 2/2/4 (the initial high phase is ignored).
//  4 CNT_W=4, y high 20 cycles, low 1, high -> m_high=15, m_low=1,
//    m_period=16, m_sat=1.
//  5 m_ready=0, y square wave 2/2 for 3 periods -> first result held, m_* stable,
//    overrun=1 after 2nd COMPLETE; raise m_ready -> next result is a new period.
//  6 Drive y from counter (clk half-period 1, 30 toggles), m_ready=1; assert
//    reset mid-HIGH -> m_valid=0 next cycle, no result until a full period after
//    WAIT_LOW/ARM; then m_period matches the counter's division ratio.

Source files
------------

// File: rtl/pulse_meter.sv
// Measures each full high/low cycle of a clk-synchronous waveform and presents
// high time, low time and period on a valid/ready output port.
//
// state    | meaning
// WAIT_LOW | after reset; wait for y=0 so a partial high phase is never measured
// ARM      | y is low; the next high sample starts the first measured period
// HIGH     | counting high samples in hi_cnt
// LOW      | counting low samples in lo_cnt; next high sample completes the period
module pulse_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             y,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_high,
    output logic [CNT_W-1:0] m_low,
    output logic [CNT_W:0]   m_period,
    output logic             m_sat,
    output logic             overrun
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARM      = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;
    logic             sat_q;
    logic             complete;
    logic             load;

    // A completed period may load even while a result is pending, provided the
    // consumer takes the old one on this same edge.
    always_comb begin
        complete = (state == LOW) && y;
        load     = complete && (!m_valid || m_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_LOW;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            sat_q    <= 1'b0;
            m_valid  <= 1'b0;
            m_high   <= '0;
            m_low    <= '0;
            m_period <= '0;
            m_sat    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOW: begin
                    if (!y) state <= ARM;
                end
                ARM: begin
                    if (y) begin
                        state  <= HIGH;
                        hi_cnt <= CNT_ONE;
                        sat_q  <= 1'b0;
                    end
                end
                HIGH: begin
                    if (y) begin
                        if (hi_cnt == CNT_MAX) sat_q <= 1'b1;
                        else                   hi_cnt <= hi_cnt + CNT_ONE;
                    end else begin
                        state  <= LOW;
                        lo_cnt <= CNT_ONE;
                    end
                end
                LOW: begin
                    if (!y) begin
                        if (lo_cnt == CNT_MAX) sat_q <= 1'b1;
                        else                   lo_cnt <= lo_cnt + CNT_ONE;
                    end else begin
                        // the rising sample is already the first high cycle of the next period
                        state  <= HIGH;
                        hi_cnt <= CNT_ONE;
                        sat_q  <= 1'b0;
                    end
                end
                default: state <= WAIT_LOW;
            endcase

            if (load) begin
                m_valid  <= 1'b1;
                m_high   <= hi_cnt;
                m_low    <= lo_cnt;
                m_period <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
                m_sat    <= sat_q;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
